mlsu_cmd_issuer: RTL
====================

Name: mlsu_cmd_issuer

Overview:
- Transmit-side counterpart of the MLSU control machine's mode decode.
- Accepts one decoded matrix load/store instruction at a time and encodes its layout into the 4-bit one-hot mode: bit0 row-major, bit1 col-major, bit2 transpose, bit3 reshape.
- Breaks the instruction into a stream of per-row or per-column commands over a valid/ready interface toward the control machine.
- Sits between the matrix instruction decoder and the MLSU control machine.

Parameters:
- ADDR_W, 32, byte address width of base, stride and command address.
- DIM_W, 8, width of row/column counts.
- LEN_W, 2*DIM_W, width of command element length.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  instruction accepted when both are high.
- in_col_i  in  1  0 = row-major, 1 = col-major.
- in_trans_i  in  1  transpose request.
- in_reshape_i  in  1  reshape request.
- in_base_i  in  ADDR_W  base address.
- in_stride_i  in  ADDR_W  address step between commands.
- in_rows_i  in  DIM_W  row count.
- in_cols_i  in  DIM_W  column count.
- cmd_valid_o  out  1  command valid.
- cmd_ready_i  in  1  command accepted when both are high.
- cmd_mode_o  out  4  one-hot mode.
- cmd_addr_o  out  ADDR_W  command start address.
- cmd_len_o  out  LEN_W  elements in this command.
- cmd_idx_o  out  DIM_W  command index within the instruction.
- cmd_last_o  out  1  final command of the instruction.
- busy_o  out  1  instruction in flight.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE.
  - All outputs are 0 except in_ready_o, which is 1.
  - All internal registers clear.
  - Reset mid-instruction abandons it with no done pulse.
- States: IDLE, ISSUE.
- IDLE:
  - in_ready_o=1, cmd_valid_o=0.
  - On an in_valid_i & in_ready_o handshake, latch all fields and encode the mode.
- Mode encoding (priority, exactly one bit set):
  - reshape → 4'b1000
  - else trans → 4'b0100
  - else col → 4'b0010
  - else → 4'b0001
- Command count N and length L:
  - row-major or transpose: N=rows, L=cols
  - col-major: N=cols, L=rows
  - reshape: N=1, L=rows*cols (full LEN_W product, no truncation)
- Zero dimension (rows==0 or cols==0):
  - The instruction is accepted and no command is issued.
  - done_o pulses the cycle after acceptance; state stays IDLE.
- Normal acceptance at cycle T: go to ISSUE; cmd_valid_o=1 from T+1.
  - First command: addr=base, idx=0.
- ISSUE:
  - in_ready_o=0, busy_o=1.
  - cmd_* fields are stable while cmd_valid_o & !cmd_ready_i.
  - On each handshake: idx+=1; addr+=stride (mod 2^ADDR_W, wrap-around allowed, no flag).
  - cmd_last_o=1 exactly when idx==N-1.
  - Handshake with cmd_last_o: go to IDLE; next cycle cmd_valid_o=0, done_o=1, in_ready_o=1.
  - A new instruction may be accepted in that same done cycle.
- Back-to-back commands at one per cycle when cmd_ready_i is held high. An instruction of N commands occupies N+1 cycles from acceptance to done.
- cmd_valid_o never drops without a handshake (except on reset).
- N=1 (non-reshape): the first command carries cmd_last_o=1.
- rows=cols=2^DIM_W-1: counters must not overflow (idx reaches 254 for DIM_W=8).
- busy_o=1 in ISSUE, 0 in IDLE.

Optional Feature:
- Macro: MLSU_CMD_ISSUER_STATS_EN.
- When defined, adds outputs:
  - stat_cmds_o [31:0]: total command handshakes.
  - stat_stall_o [31:0]: cycles with cmd_valid_o & !cmd_ready_i.
  - Both clear on reset and saturate at all-ones.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Row-major: rows=3, cols=4, base=0x1000, stride=0x40, cmd_ready_i=1.
  - Expect mode=0001, addrs 0x1000/0x1040/0x1080, len=4, idx 0..2, last on idx 2.
  - done at acceptance+4.
- Col-major: rows=2, cols=3, stride=0x10, with cmd_ready_i low 2 cycles on the first command.
  - Expect mode=0010, 3 commands, len=2.
  - Fields stable during the stall; with stats enabled, stat_stall_o=2.
- Reshape with trans=1, col=1: rows=16, cols=16.
  - Expect mode=1000, a single command, len=256, last=1.
- Zero dimension: rows=0, cols=5.
  - Expect no cmd_valid_o; done_o pulses at acceptance+1; in_ready_o stays 1.
- Wrap and back-to-back: base=0xFFFF_FFF0, stride=0x10, rows=2, then a second instruction presented during the done cycle.
  - Expect addrs 0xFFFF_FFF0 then 0x0000_0000; second instruction accepted in the done cycle.
- Reset mid-ISSUE after 1 of 3 commands.
  - Expect next cycle cmd_valid_o=0, in_ready_o=1, busy_o=0, and no done_o pulse.

Source files
------------

// File: rtl/mlsu_cmd_issuer.sv
// mlsu_cmd_issuer: splits one decoded matrix load/store instruction into a
// stream of per-row / per-column commands toward the MLSU control machine,
// tagging each command with the 4-bit one-hot layout mode.
// Optional build macro MLSU_CMD_ISSUER_STATS_EN adds handshake/stall counters.
module mlsu_cmd_issuer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned LEN_W  = 2 * DIM_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_col_i,
    input  logic              in_trans_i,
    input  logic              in_reshape_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [ADDR_W-1:0] in_stride_i,
    input  logic [DIM_W-1:0]  in_rows_i,
    input  logic [DIM_W-1:0]  in_cols_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [3:0]        cmd_mode_o,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [LEN_W-1:0]  cmd_len_o,
    output logic [DIM_W-1:0]  cmd_idx_o,
    output logic              cmd_last_o,
    output logic              busy_o,
    output logic              done_o
`ifdef MLSU_CMD_ISSUER_STATS_EN
    ,
    output logic [31:0]       stat_cmds_o,
    output logic [31:0]       stat_stall_o
`endif
);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e            state_q, state_d;
    logic [3:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DIM_W-1:0]  idx_q, idx_d;
    logic [DIM_W-1:0]  nlast_q, nlast_d;
    logic              done_q, done_d;

    logic [3:0]        acc_mode;
    logic [LEN_W-1:0]  acc_len;
    logic [DIM_W-1:0]  acc_n;
    logic              acc_zero;
    logic              is_last;

    // Decode the incoming instruction: priority-encoded mode, command count and length
    always_comb begin
        acc_mode = 4'b0001;
        acc_n    = in_rows_i;
        acc_len  = LEN_W'(in_cols_i);
        acc_zero = (in_rows_i == '0) || (in_cols_i == '0);
        if (in_reshape_i) begin
            acc_mode = 4'b1000;
            acc_n    = DIM_W'(1);
            acc_len  = LEN_W'(in_rows_i) * LEN_W'(in_cols_i);
        end else if (in_trans_i) begin
            acc_mode = 4'b0100;
        end else if (in_col_i) begin
            acc_mode = 4'b0010;
            acc_n    = in_cols_i;
            acc_len  = LEN_W'(in_rows_i);
        end
    end

    assign is_last = (idx_q == nlast_q);

    // Next-state logic: accept in IDLE, step address/index per command handshake in ISSUE
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        len_d    = len_q;
        idx_d    = idx_q;
        nlast_d  = nlast_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    mode_d   = acc_mode;
                    addr_d   = in_base_i;
                    stride_d = in_stride_i;
                    len_d    = acc_len;
                    idx_d    = '0;
                    nlast_d  = acc_n - DIM_W'(1);
                    if (acc_zero) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready_i) begin
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + DIM_W'(1);
                        addr_d = addr_q + stride_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            nlast_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            nlast_q  <= nlast_d;
            done_q   <= done_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign cmd_valid_o = (state_q == ISSUE);
    assign busy_o      = (state_q == ISSUE);
    // idx==nlast also holds after reset, so last is qualified by ISSUE
    assign cmd_last_o  = (state_q == ISSUE) && is_last;
    assign cmd_mode_o  = mode_q;
    assign cmd_addr_o  = addr_q;
    assign cmd_len_o   = len_q;
    assign cmd_idx_o   = idx_q;
    assign done_o      = done_q;

`ifdef MLSU_CMD_ISSUER_STATS_EN
    logic [31:0] stat_cmds_q, stat_stall_q;

    // Saturating counters of command handshakes and stalled command cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_cmds_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (cmd_valid_o && cmd_ready_i && (stat_cmds_q != '1)) begin
                stat_cmds_q <= stat_cmds_q + 32'd1;
            end
            if (cmd_valid_o && !cmd_ready_i && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_cmds_o  = stat_cmds_q;
    assign stat_stall_o = stat_stall_q;
`endif

endmodule
